// File: rtl/clock_pkg.sv
// Shared time-of-day constants and the RUN/HOLD encoding used by the mode
// controller, this datapath and the calendar counter.
package clock_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned SEC_MAX  = 59;

    typedef enum logic {
        ModeHold = 1'b0,
        ModeRun  = 1'b1
    } run_mode_e;

endpackage

// File: rtl/bin2bcd2.sv
// 6-bit binary (0-59) to two packed BCD digits {tens, ones} via shift-and-add-3.
module bin2bcd2 (
    input  logic [5:0] bin_i,
    output logic [7:0] bcd_o
);

    logic [13:0] s;

    always_comb begin
        s = {8'b0, bin_i};
        for (int i = 0; i < 6; i++) begin
            if (s[9:6] >= 4'd5) s[9:6] = s[9:6] + 4'd3;
            if (s[13:10] >= 4'd5) s[13:10] = s[13:10] + 4'd3;
            s = s << 1;
        end
        bcd_o = s[13:6];
    end

endmodule

// File: rtl/timekeeper_core.sv
// Hours/minutes/seconds datapath with 1 Hz prescaler, HOLD-mode single-step
// adjustment, midnight day_carry pulse and 12/24-hour BCD display outputs.
module timekeeper_core
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clockon,
    input  logic              hset,
    input  logic              mset,
    input  logic              inc,
    input  logic              h1224,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic              pm,
    output logic [7:0]        hour_bcd,
    output logic [7:0]        min_bcd,
    output logic [7:0]        sec_bcd,
    output logic              day_carry
);

    localparam int unsigned     PrescW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_HZ - 1);

    logic [HOUR_W-1:0] hour_q, hour_d, disp_hour;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [PrescW-1:0] presc_q, presc_d, presc_cur;
    logic              day_carry_q, day_carry_d;
    logic              clockon_q;
    logic              tick, sec_wrap, min_wrap, hour_wrap;
    run_mode_e         mode;

    always_comb begin
        mode      = run_mode_e'(clockon);
        // A fresh RUN period always counts a full second before its first tick.
        presc_cur = (clockon && !clockon_q) ? '0 : presc_q;
        tick      = (mode == ModeRun) && (presc_cur == PrescMax);
        // >= rather than == so a corrupted field recovers to 0 on its next step.
        sec_wrap  = sec_q >= SEC_W'(SEC_MAX);
        min_wrap  = min_q >= MIN_W'(MIN_MAX);
        hour_wrap = hour_q >= HOUR_W'(HOUR_MAX);

        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        presc_d     = presc_q;
        day_carry_d = 1'b0;

        if (mode == ModeRun) begin
            presc_d = tick ? '0 : presc_cur + PrescW'(1);
            if (tick) begin
                sec_d = sec_wrap ? '0 : sec_q + SEC_W'(1);
                if (sec_wrap) begin
                    min_d = min_wrap ? '0 : min_q + MIN_W'(1);
                    if (min_wrap) begin
                        hour_d      = hour_wrap ? '0 : hour_q + HOUR_W'(1);
                        day_carry_d = hour_wrap;
                    end
                end
            end
        end else begin
            presc_d = '0;
            if (inc) begin
                if (hset) begin
                    hour_d = hour_wrap ? '0 : hour_q + HOUR_W'(1);
                end else if (mset) begin
                    min_d = min_wrap ? '0 : min_q + MIN_W'(1);
                    sec_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            presc_q     <= '0;
            day_carry_q <= 1'b0;
            clockon_q   <= 1'b0;
        end else begin
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            presc_q     <= presc_d;
            day_carry_q <= day_carry_d;
            clockon_q   <= clockon;
        end
    end

    always_comb begin
        if (h1224 && (hour_q == '0)) begin
            disp_hour = HOUR_W'(12);
        end else if (h1224 && (hour_q > HOUR_W'(12))) begin
            disp_hour = hour_q - HOUR_W'(12);
        end else begin
            disp_hour = hour_q;
        end
    end

    assign hour      = hour_q;
    assign min       = min_q;
    assign sec       = sec_q;
    assign pm        = hour_q >= HOUR_W'(12);
    assign day_carry = day_carry_q;

    bin2bcd2 u_hour_bcd (
        .bin_i(6'(disp_hour)),
        .bcd_o(hour_bcd)
    );

    bin2bcd2 u_min_bcd (
        .bin_i(6'(min_q)),
        .bcd_o(min_bcd)
    );

    bin2bcd2 u_sec_bcd (
        .bin_i(6'(sec_q)),
        .bcd_o(sec_bcd)
    );

endmodule

// File: tb/tb_timekeeper_core.sv
// Directed bench for timekeeper_core at CLK_HZ=4 with hand-computed expectations.
module tb_timekeeper_core;

    localparam int unsigned ClkHz = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clockon = 1'b0;
    logic       hset = 1'b0;
    logic       mset = 1'b0;
    logic       inc = 1'b0;
    logic       h1224 = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       pm;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       day_carry;

    int n_tests = 0;
    int n_fail  = 0;
    int dc_cnt  = 0;
    int dc0;
    int got;

    timekeeper_core #(
        .CLK_HZ(ClkHz)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clockon  (clockon),
        .hset     (hset),
        .mset     (mset),
        .inc      (inc),
        .h1224    (h1224),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .pm       (pm),
        .hour_bcd (hour_bcd),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .day_carry(day_carry)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance n cycles; inputs change and outputs are sampled at the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (day_carry) dc_cnt++;
        end
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            inc = 1'b1;
            step(1);
            inc = 1'b0;
            step(1);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check_eq({tag, "_hour"}, int'(hour), h);
        check_eq({tag, "_min"}, int'(min), m);
        check_eq({tag, "_sec"}, int'(sec), s);
    endtask

    initial begin
        #2 reset = 1'b0;
        step(2);
        check_time("reset", 0, 0, 0);
        check_eq("reset_pm", int'(pm), 0);
        check_eq("reset_hour_bcd24", int'(hour_bcd), 'h00);
        check_eq("reset_day_carry", int'(day_carry), 0);
        h1224 = 1'b1;
        #1 check_eq("reset_hour_bcd12", int'(hour_bcd), 'h12);
        h1224 = 1'b0;

        // First tick lands on the 4th RUN cycle after release.
        @(negedge clk);
        reset   = 1'b1;
        clockon = 1'b1;
        step(3);
        check_eq("pre_first_tick_sec", int'(sec), 0);
        step(1);
        check_eq("first_tick_sec", int'(sec), 1);
        step(8);
        check_eq("run12_sec", int'(sec), 3);
        check_eq("run12_sec_bcd", int'(sec_bcd), 'h03);
        clockon = 1'b0;
        step(1);

        // Build 23:59:58, then run through midnight.
        hset = 1'b1;
        pulse(23);
        hset = 1'b0;
        mset = 1'b1;
        pulse(59);
        mset = 1'b0;
        check_time("set_2359", 23, 59, 0);
        clockon = 1'b1;
        step(58 * ClkHz);
        clockon = 1'b0;
        step(1);
        check_time("at_235958", 23, 59, 58);
        dc0 = dc_cnt;
        clockon = 1'b1;
        step(7);
        check_time("at_235959", 23, 59, 59);
        check_eq("pre_midnight_carry", int'(day_carry), 0);
        step(1);
        check_time("midnight", 0, 0, 0);
        check_eq("midnight_carry", int'(day_carry), 1);
        clockon = 1'b0;
        step(1);
        check_eq("post_midnight_carry", int'(day_carry), 0);
        check_eq("carry_pulse_count", dc_cnt - dc0, 1);

        // 25 hour steps wrap through 23 without a day carry.
        dc0 = dc_cnt;
        hset = 1'b1;
        pulse(25);
        hset = 1'b0;
        check_time("hset25", 1, 0, 0);
        check_eq("hset25_no_carry", dc_cnt - dc0, 0);

        // 12:59:37 + minute step -> 12:00:00.
        hset = 1'b1;
        pulse(11);
        hset = 1'b0;
        mset = 1'b1;
        pulse(59);
        mset = 1'b0;
        clockon = 1'b1;
        step(37 * ClkHz);
        clockon = 1'b0;
        step(1);
        check_time("at_125937", 12, 59, 37);
        mset = 1'b1;
        pulse(1);
        mset = 1'b0;
        check_time("mset_wrap", 12, 0, 0);

        // Both selects: hour wins at 05:10:20.
        hset = 1'b1;
        pulse(17);
        hset = 1'b0;
        mset = 1'b1;
        pulse(10);
        mset = 1'b0;
        clockon = 1'b1;
        step(20 * ClkHz);
        clockon = 1'b0;
        step(1);
        check_time("at_051020", 5, 10, 20);
        hset = 1'b1;
        mset = 1'b1;
        pulse(1);
        hset = 1'b0;
        mset = 1'b0;
        check_time("hset_priority", 6, 10, 20);
        check_eq("min_bcd_10", int'(min_bcd), 'h10);
        check_eq("sec_bcd_20", int'(sec_bcd), 'h20);
        pulse(1);
        check_time("inc_no_select", 6, 10, 20);

        // 12-hour mapping.
        hset = 1'b1;
        pulse(18);
        h1224 = 1'b1;
        #1;
        check_eq("h12_hour0_bcd", int'(hour_bcd), 'h12);
        check_eq("h12_hour0_pm", int'(pm), 0);
        pulse(12);
        #1;
        check_eq("h12_hour12_bcd", int'(hour_bcd), 'h12);
        check_eq("h12_hour12_pm", int'(pm), 1);
        pulse(1);
        #1;
        check_eq("h12_hour13_bcd", int'(hour_bcd), 'h01);
        check_eq("h12_hour13_pm", int'(pm), 1);
        h1224 = 1'b0;
        #1 check_eq("h24_hour13_bcd", int'(hour_bcd), 'h13);
        hset = 1'b0;

        // Asynchronous reset mid-count, then a full prescaler period to the next tick.
        @(negedge clk);
        clockon = 1'b1;
        step(2);
        #2 reset = 1'b0;
        #1;
        check_time("async_reset", 0, 0, 0);
        step(1);
        reset = 1'b1;
        got = -1;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            if (got < 0 && sec == 6'd1) got = c;
        end
        check_eq("post_reset_tick_cycle", got, 4);
        check_eq("post_reset_hour", int'(hour), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
